// File: rtl/rotary_encoder_decoder.sv
// Four-channel rotary encoder decoder: per-channel debounce, Gray quarter-step
// decode, detent accumulation and saturating position counters.
module rotary_encoder_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES  = 16,
    parameter int unsigned STEPS_PER_DETENT = 4,
    parameter int unsigned POS_WIDTH        = 8,
    parameter int unsigned MAX_POS          = 255,
    parameter int unsigned POS_RESET        = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           re_1,
    input  logic [1:0]           re_2,
    input  logic [1:0]           re_3,
    input  logic [1:0]           re_4,
    input  logic                 pos_clear,
    output logic [POS_WIDTH-1:0] pos_1,
    output logic [POS_WIDTH-1:0] pos_2,
    output logic [POS_WIDTH-1:0] pos_3,
    output logic [POS_WIDTH-1:0] pos_4,
    output logic [3:0]           step_up,
    output logic [3:0]           step_dn,
    output logic [3:0]           err
);

    localparam logic [15:0]          CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic signed [3:0]    SUB_TOP  = 4'(STEPS_PER_DETENT);
    localparam logic signed [3:0]    SUB_BOT  = -SUB_TOP;
    localparam logic [POS_WIDTH-1:0] POS_MAX  = POS_WIDTH'(MAX_POS);
    localparam logic [POS_WIDTH-1:0] POS_INIT = POS_WIDTH'(POS_RESET);

    logic [1:0]           raw      [4];
    logic [3:0]           primed_q, primed_d;
    logic [1:0]           stable_q [4];
    logic [1:0]           stable_d [4];
    logic [1:0]           cand_q   [4];
    logic [1:0]           cand_d   [4];
    logic [15:0]          cnt_q    [4];
    logic [15:0]          cnt_d    [4];
    logic signed [3:0]    sub_q    [4];
    logic signed [3:0]    sub_d    [4];
    logic [POS_WIDTH-1:0] pos_q    [4];
    logic [POS_WIDTH-1:0] pos_d    [4];
    logic [3:0]           up_q, up_d, dn_q, dn_d, err_q, err_d;

    assign raw[0] = re_1;
    assign raw[1] = re_2;
    assign raw[2] = re_3;
    assign raw[3] = re_4;

    // Gray phase to quadrature index, so that CW is +1 and a double-bit jump is +2 (mod 4)
    function automatic logic [1:0] gray_to_bin(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    always_comb begin
        logic [1:0]        dir;
        logic signed [3:0] sub_next;
        primed_d = primed_q;
        up_d     = '0;
        dn_d     = '0;
        err_d    = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            dir         = '0;
            sub_next    = sub_q[i];
            stable_d[i] = stable_q[i];
            cand_d[i]   = cand_q[i];
            cnt_d[i]    = cnt_q[i];
            sub_d[i]    = sub_q[i];
            pos_d[i]    = pos_q[i];

            if (!primed_q[i]) begin
                stable_d[i] = raw[i];
                cand_d[i]   = raw[i];
                cnt_d[i]    = '0;
                primed_d[i] = 1'b1;
            end else if (raw[i] != cand_q[i]) begin
                cand_d[i] = raw[i];
                cnt_d[i]  = '0;
            end else if (cand_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = cand_q[i];
                    cnt_d[i]    = '0;
                    dir         = gray_to_bin(cand_q[i]) - gray_to_bin(stable_q[i]);
                end else begin
                    cnt_d[i] = cnt_q[i] + 16'd1;
                end
            end else begin
                cnt_d[i] = '0;
            end

            // dir stays 0 unless a debounced transition was accepted this cycle
            case (dir)
                2'd1:    sub_next = sub_q[i] + 4'sd1;
                2'd3:    sub_next = sub_q[i] - 4'sd1;
                2'd2: begin
                    err_d[i] = 1'b1;
                    sub_next = '0;
                end
                default: sub_next = sub_q[i];
            endcase

            if (sub_next == SUB_TOP) begin
                up_d[i]  = 1'b1;
                sub_d[i] = '0;
                if (pos_q[i] < POS_MAX) pos_d[i] = pos_q[i] + 1'b1;
            end else if (sub_next == SUB_BOT) begin
                dn_d[i]  = 1'b1;
                sub_d[i] = '0;
                if (pos_q[i] != '0) pos_d[i] = pos_q[i] - 1'b1;
            end else begin
                sub_d[i] = sub_next;
            end

            if (pos_clear) pos_d[i] = POS_INIT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            primed_q <= '0;
            up_q     <= '0;
            dn_q     <= '0;
            err_q    <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                stable_q[i] <= '0;
                cand_q[i]   <= '0;
                cnt_q[i]    <= '0;
                sub_q[i]    <= '0;
                pos_q[i]    <= POS_INIT;
            end
        end else begin
            primed_q <= primed_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
            err_q    <= err_d;
            for (int unsigned i = 0; i < 4; i++) begin
                stable_q[i] <= stable_d[i];
                cand_q[i]   <= cand_d[i];
                cnt_q[i]    <= cnt_d[i];
                sub_q[i]    <= sub_d[i];
                pos_q[i]    <= pos_d[i];
            end
        end
    end

    assign pos_1   = pos_q[0];
    assign pos_2   = pos_q[1];
    assign pos_3   = pos_q[2];
    assign pos_4   = pos_q[3];
    assign step_up = up_q;
    assign step_dn = dn_q;
    assign err     = err_q;

endmodule
